// File: rtl/sync_up_counter_if.sv
// ---------------------------------------------------------------------------
// sync_up_counter_if
//   Groups the control and status signals of one sync_up_counter stage.
//   The master side (a controller, or the previous stage of a cascade via tc)
//   drives the controls; the slave side is the counter itself.
//
//   Signals
//     en       count enable / cascade input from a lower stage's tc
//     load     synchronous parallel load of din
//     din      load value (WIDTH bits)
//     clr_ovf  clears the sticky overflow flag
//     q        current count (registered)
//     tc       terminal count, combinational: (q == MODULUS-1) && en
//     wrap     registered one-cycle pulse after a wrap to 0
//     ovf      sticky overflow, set on any wrap
// ---------------------------------------------------------------------------
interface sync_up_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, load, din, clr_ovf,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  en, load, din, clr_ovf,
    output q, tc, wrap, ovf
  );
endinterface

// File: rtl/sync_up_counter.sv
// ---------------------------------------------------------------------------
// sync_up_counter
//   Synchronous modulo-MODULUS up counter. Every bit of q updates on the same
//   clock edge, so q never shows ripple glitches. Offers parallel load (with
//   clamping to MODULUS-1), count enable, a combinational terminal count for
//   cascading, a one-cycle wrap pulse and a sticky overflow flag.
//
//   Parameters
//     WIDTH      counter width in bits (>= 1)
//     MODULUS    count sequence 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//     RESET_VAL  value of q after reset (< MODULUS)
//
//   Ports
//     clk    clock, all state updates on its rising edge
//     reset  synchronous reset, active-low (0 = reset)
//     bus    sync_up_counter_if slave modport (en, load, din, clr_ovf in;
//            q, tc, wrap, ovf out)
// ---------------------------------------------------------------------------
module sync_up_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic               clk,
  input  logic               reset,
  sync_up_counter_if.slave   bus
);

  // MAX_VAL is computed in WIDTH bits so that MODULUS == 2**WIDTH gives all
  // ones; "din < MODULUS" is then the same test as "din <= MAX_VAL".
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             atMax;

  assign atMax = (count_q == MAX_VAL);

  // Load beats enable; a wrap on the same edge as clr_ovf keeps ovf set,
  // which falls out of the wrap branch overriding the clear below.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (bus.load) begin
      count_d = (bus.din > MAX_VAL) ? MAX_VAL : bus.din;
    end else if (bus.en) begin
      if (atMax) begin
        count_d = '0;
        wrap_d  = 1'b1;
        ovf_d   = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= RST_Q;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // tc is combinational so a cascaded stage increments on the same edge.
  assign bus.tc   = atMax && bus.en;
  assign bus.q    = count_q;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;

endmodule
